// File: rtl/core_pkg.sv
// core_pkg: shared constants for the fetch front end
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: flushable ring-buffer FIFO with combinational head read
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= wdata;
  assign rdata = mem[rptr];
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: in-order instruction prefetch buffer with redirect flush
module instr_prefetch_queue
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            de_stall,
  input  logic            ex_pc_src,
  input  logic [XLEN-1:0] ex_pc_target,
  output logic            de_valid,
  output logic [31:0]     de_instr,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [OW-1:0] live_out, drop_cnt;
  logic [QW-1:0] count;
  logic [31+XLEN:0] head;
  logic fire, rsp_ok, push, pop;
  always_comb begin
    mem_req_valid = ~reset & ~ex_pc_src & (int'(count) + int'(live_out) < DEPTH)
                  & (int'(live_out) + int'(drop_cnt) < MAX_OUT);
    fire = mem_req_valid & mem_req_ready;
    rsp_ok = mem_rsp_valid & ((live_out != '0) | (drop_cnt != '0));
    push = rsp_ok & (drop_cnt == '0) & ~ex_pc_src;
    pop = de_valid & ~de_stall & ~ex_pc_src;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      live_out <= '0;
      drop_cnt <= '0;
    end else if (ex_pc_src) begin
      fetch_pc <= ex_pc_target;
      rsp_pc <= ex_pc_target;
      live_out <= '0;
      // every response still in flight, live or already doomed, must now be discarded
      drop_cnt <= drop_cnt + live_out - OW'(rsp_ok);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (push) rsp_pc <= rsp_pc + XLEN'(4);
      live_out <= live_out + OW'(fire) - OW'(push);
      drop_cnt <= drop_cnt - OW'(rsp_ok & (drop_cnt != '0));
    end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32 + XLEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(ex_pc_src),
    .push(push),
    .pop(pop),
    .wdata({mem_rsp_data, rsp_pc}),
    .rdata(head),
    .count(count)
  );
  assign mem_req_addr = fetch_pc;
  assign de_valid = count != '0;
  assign de_instr = de_valid ? head[XLEN+31:XLEN] : NOP_INSTR;
  assign de_pc = de_valid ? head[XLEN-1:0] : '0;
  assign de_pc_plus4 = de_valid ? head[XLEN-1:0] + XLEN'(4) : '0;
  a_rsp_outstanding: assert property (@(posedge clk) disable iff (reset)
    mem_rsp_valid |-> (live_out != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized scoreboard bench against an epoch-based fetch model
module tb_instr_prefetch_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, reset = 1;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid, de_stall, ex_pc_src, de_valid;
  logic [31:0] mem_req_addr, mem_rsp_data, ex_pc_target, de_instr, de_pc, de_pc_plus4;
  typedef struct {logic [31:0] addr; int ep; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; int cyc;} exp_t;
  req_t memq[$];
  exp_t expq[$];
  int cyc = 0, ep = 0, n_cmp = 0, n_bad = 0;
  int p_rdy = 100, p_rsp = 100, p_stall = 0, p_redir = 0, lat_min = 1, lat_max = 1;
  logic [31:0] fpc = 0, rpc = 0, prev_a = 0;
  bit prev_v = 0, prev_redir = 0;

  instr_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .de_stall(de_stall), .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
    .de_valid(de_valid), .de_instr(de_instr), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] hf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one cycle of random stimulus plus the in-order memory responder
  task automatic step();
    @(posedge clk);
    #1;
    mem_req_ready = int'($urandom_range(99)) < p_rdy;
    de_stall = int'($urandom_range(99)) < p_stall;
    ex_pc_src = !reset && int'($urandom_range(99)) < p_redir;
    ex_pc_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
    if (!reset && memq.size() != 0 && memq[0].due <= cyc && int'($urandom_range(99)) < p_rsp) begin
      mem_rsp_valid = 1;
      mem_rsp_data = hf(memq[0].addr);
    end else begin
      mem_rsp_valid = 0;
      mem_rsp_data = $urandom;
    end
  endtask

  task automatic redirect(logic [31:0] t);
    step();
    ex_pc_src = 1;
    ex_pc_target = t;
  endtask

  // reference model: requests tagged with the fetch epoch; only current-epoch words are delivered
  always @(negedge clk) begin : model
    int live;
    req_t e;
    if (reset) prev_v = 0;
    else begin
      live = 0;
      foreach (memq[i]) if (memq[i].ep == ep) live++;
      chk("req_valid", 64'(mem_req_valid),
          64'(!ex_pc_src && expq.size() + live < DEPTH && memq.size() < MAX_OUT));
      if (prev_v && !ex_pc_src) chk("req_hold", {mem_req_valid, mem_req_addr}, {1'b1, prev_a});
      if (mem_req_valid && mem_req_ready) begin
        chk("req_addr", 64'(mem_req_addr), 64'(fpc));
        memq.push_back('{mem_req_addr, ep, cyc + int'($urandom_range(lat_max, lat_min))});
        fpc += 4;
      end
      if (mem_rsp_valid) begin
        e = memq.pop_front();
        if (!ex_pc_src && e.ep == ep) begin
          expq.push_back('{rpc, hf(rpc), cyc});
          rpc += 4;
        end
      end
      if (ex_pc_src) begin
        ep++;
        fpc = ex_pc_target;
        rpc = ex_pc_target;
        expq.delete();
      end
      prev_v = mem_req_valid && !mem_req_ready;
      prev_a = mem_req_addr;
    end
  end

  always @(negedge clk) begin : monitor
    bit has;
    logic [31:0] p4;
    #1;
    if (reset) prev_redir = 0;
    else begin
      if (prev_redir) chk("flush_valid", 64'(de_valid), 64'(0));
      if (!ex_pc_src) begin
        has = expq.size() != 0 && expq[0].cyc < cyc;
        chk("head_valid", 64'(de_valid), 64'(has));
        if (de_valid && has) begin
          p4 = expq[0].pc + 32'd4;
          chk("de_pc", 64'(de_pc), 64'(expq[0].pc));
          chk("de_instr", 64'(de_instr), 64'(expq[0].instr));
          chk("de_pc_plus4", 64'(de_pc_plus4), 64'(p4));
          if (!de_stall) void'(expq.pop_front());
        end
        if (!de_valid) begin
          chk("idle_instr", 64'(de_instr), 64'(NOP));
          chk("idle_pc", 64'(de_pc), 64'(0));
          chk("idle_pc4", 64'(de_pc_plus4), 64'(0));
        end
      end
      prev_redir = ex_pc_src;
    end
  end

  initial begin
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    de_stall = 0; ex_pc_src = 0; ex_pc_target = 0;
    #7;
    chk("rst_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_de_valid", 64'(de_valid), 64'(0));
    chk("rst_de_instr", 64'(de_instr), 64'(NOP));
    chk("rst_de_pc", 64'(de_pc), 64'(0));
    chk("rst_req_addr", 64'(mem_req_addr), 64'(0));
    // streaming after reset release: request, response, then decode
    step(); reset = 0; #3;
    chk("first_req_valid", 64'(mem_req_valid), 64'(1));
    chk("first_req_addr", 64'(mem_req_addr), 64'(0));
    step(); #3;
    chk("lat_n1_valid", 64'(de_valid), 64'(0));
    step(); #3;
    chk("lat_n2_valid", 64'(de_valid), 64'(1));
    chk("lat_n2_pc", 64'(de_pc), 64'(0));
    repeat (6) step();
    // decode stall saturates the queue
    p_stall = 100;
    repeat (10) step();
    #3;
    chk("sat_req_valid", 64'(mem_req_valid), 64'(0));
    chk("sat_queue_len", 64'(expq.size()), 64'(DEPTH));
    chk("sat_outstanding", 64'(memq.size()), 64'(0));
    p_stall = 0;
    repeat (8) step();
    // memory back-pressure holds the request
    p_rdy = 0;
    repeat (5) step();
    p_rdy = 100;
    repeat (4) step();
    // redirect with two requests outstanding
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) step();
    chk("two_outstanding", 64'(memq.size()), 64'(2));
    redirect(32'h100);
    repeat (12) step();
    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30 && !(mem_rsp_valid && de_valid && !de_stall); i++) step();
    chk("rsp_pop_setup", 64'(mem_rsp_valid && de_valid), 64'(1));
    ex_pc_src = 1; ex_pc_target = 32'h40;
    repeat (8) step();
    // back-to-back redirects while drops are pending
    lat_min = 4; lat_max = 4;
    repeat (3) step();
    redirect(32'h200);
    redirect(32'h300);
    repeat (20) step();
    // randomized traffic
    for (int b = 0; b < 40; b++) begin
      p_rdy = $urandom_range(100, 20); p_rsp = $urandom_range(100, 20);
      p_stall = $urandom_range(70); p_redir = $urandom_range(10);
      lat_min = $urandom_range(3, 1); lat_max = lat_min + int'($urandom_range(3));
      repeat (60) step();
    end
    // asynchronous reset between clock edges
    step(); #2; reset = 1; #1;
    chk("async_req_valid", 64'(mem_req_valid), 64'(0));
    chk("async_de_valid", 64'(de_valid), 64'(0));
    chk("async_de_instr", 64'(de_instr), 64'(NOP));
    chk("async_de_pc", 64'(de_pc), 64'(0));
    memq.delete(); expq.delete(); ep++; fpc = 0; rpc = 0;
    repeat (2) step();
    step(); reset = 0; #3;
    chk("restart_req_valid", 64'(mem_req_valid), 64'(1));
    chk("restart_req_addr", 64'(mem_req_addr), 64'(0));
    repeat (40) step();
    p_redir = 0; p_stall = 0; p_rsp = 100; p_rdy = 100;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
